uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART receiver; the receive-side counterpart of `uart_tx`, using the same frame format and parameter set.
- Converts an asynchronous serial line into parallel words using mid-bit sampling.
- Output: a one-cycle `valid` strobe per frame, plus per-frame parity and framing error flags.
- Sits between the board RX pin and the user logic; a bench loops it back against `uart_tx`.

Parameters:
- SYSCLK_FREQUENCY_HZ, 100000000, system clock frequency in Hz.
- BAUDRATE, 115200, line bit rate.
- DATA_LENGTH, 8, data bits per frame (5..9), LSB first.
- DOUBLE_STOPBIT, 1'b0, 1 = two stop bits expected.
- PARITY, 1'b1, 1 = one odd-parity bit follows the data (ones in data+parity is odd); 0 = no parity bit.

Ports:
- sysclk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- serial  input  1  asynchronous RX line, idle high.
- data  output  DATA_LENGTH  last received word; held until next frame completes.
- valid  output  1  one-cycle pulse when a frame completes.
- parity_error  output  1  parity check result for the frame, valid with `valid`.
- frame_error  output  1  a stop bit was sampled low, valid with `valid`.

Behaviour:
- Timing constants:
  - RATIO = SYSCLK_FREQUENCY_HZ / BAUDRATE (integer division); RATIO >= 4 required.
  - HALF = RATIO/2 (floor).
  - Bit counter width is $clog2(RATIO).
- Reset values: data=0, valid=0, parity_error=0, frame_error=0, state=IDLE, synchronizer flops=1.
- Reset is asynchronous and may arrive mid-frame: everything returns to reset values immediately, the partial frame is discarded, and no `valid` is issued for it.
- Input synchronizer: `serial` passes through 2 flops (rxs). Total latency from the pin is 2 cycles; all decisions use rxs.
- IDLE:
  - Stay while rxs=1.
  - On rxs=0, go to START with cnt=0.
- START:
  - cnt counts up. When cnt=HALF-1, sample rxs.
  - Sample 1 (glitch): return to IDLE, no outputs change.
  - Sample 0: cnt=0, bit index=0, go to DATA.
- DATA:
  - Sample rxs when cnt=RATIO-1, i.e. at the middle of each bit. Shift into the MSB of the shift register, so LSB-first reception ends aligned.
  - After DATA_LENGTH samples, go to PARITY if PARITY=1, otherwise STOP.
- PARITY:
  - Sample once at cnt=RATIO-1.
  - perr = ~(^{shift, sample}), i.e. 1 when the total count of ones is even.
- STOP:
  - Sample at cnt=RATIO-1. Low sample sets the ferr flag.
  - If DOUBLE_STOPBIT=1, go to STOP2, which samples the same way and ORs into ferr.
  - After the final stop sample, on the next edge: data<=shift, parity_error<=perr (0 when PARITY=0), frame_error<=ferr, valid<=1 for exactly one cycle.
- Return to IDLE after the final stop sample:
  - ferr=0: next state IDLE; a new start edge is accepted immediately, so back-to-back frames are supported with no idle gap.
  - ferr=1: next state WAIT_HIGH.
- WAIT_HIGH: stay until rxs=1, then IDLE. A break condition (line held low) therefore produces exactly one `valid`, carrying frame_error=1.
- Error reporting:
  - `data` is updated even on error frames; consumers must qualify it with the error flags.
  - Error flags change only on `valid` cycles and hold otherwise.
- States: IDLE, START, DATA, PARITY, STOP, STOP2, WAIT_HIGH. Unreachable encodings return to IDLE.
- Frame-to-valid latency: the `valid` rising edge occurs 2 (sync) + HALF + RATIO×(DATA_LENGTH+PARITY+1+DOUBLE_STOPBIT) + 1 cycles after the start-bit falling edge on `serial`, ±1 cycle of sync phase.

Test Plan:
- Bench configuration: RATIO=4, DATA_LENGTH=8, PARITY=1, DOUBLE_STOPBIT=0 unless noted.
- Frame 8'b10100111, parity 0, stop 1 -> one `valid` pulse, data=8'hA7, parity_error=0, frame_error=0.
- Frame 8'b00100111 with parity 0 (wrong) -> valid, data=8'h27, parity_error=1, frame_error=0. Repeat with parity 1 -> parity_error=0.
- Frame 8'h55, correct parity, stop bit driven 0, then line held low 20 bit times -> exactly one valid, frame_error=1. No further valid until the line goes high. A following 8'h3C frame is received cleanly.
- 1-cycle low glitch on an idle line -> no valid; state back in IDLE within HALF+2 cycles. A frame sent immediately afterwards (8'hF0) is received correctly.
- reset_n pulsed low during data bit 4 of a frame -> outputs 0 immediately, no valid for that frame. The next full 8'h81 frame gives data=8'h81 with no errors.
- DOUBLE_STOPBIT=1: two back-to-back frames 8'h01, 8'hFE with no idle gap -> two valids, both error-free. A third frame with the second stop bit low -> frame_error=1.

Source files
------------

// File: rtl/uart_rx.sv
// ============================================================================
// Module      : uart_rx
// Description : UART receiver with mid-bit sampling, odd parity and framing
//               checks; one-cycle valid strobe per received frame.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx #(
    parameter int SYSCLK_FREQUENCY_HZ = 100000000,
    parameter int BAUDRATE            = 115200,
    parameter int DATA_LENGTH         = 8,
    parameter bit DOUBLE_STOPBIT      = 1'b0,
    parameter bit PARITY              = 1'b1
) (
    input  logic                   sysclk,
    input  logic                   reset_n,
    input  logic                   serial,
    output logic [DATA_LENGTH-1:0] data,
    output logic                   valid,
    output logic                   parity_error,
    output logic                   frame_error
);

    localparam int c_RATIO = SYSCLK_FREQUENCY_HZ / BAUDRATE;
    localparam int c_HALF  = c_RATIO / 2;
    localparam int c_CW    = $clog2(c_RATIO);
    localparam int c_BW    = $clog2(DATA_LENGTH);

    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(c_RATIO - 1);
    localparam logic [c_CW-1:0] c_CNT_HALF = c_CW'(c_HALF - 1);
    localparam logic [c_BW-1:0] c_BIT_LAST = c_BW'(DATA_LENGTH - 1);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_START     = 3'd1;
    localparam logic [2:0] c_DATA      = 3'd2;
    localparam logic [2:0] c_PARITY    = 3'd3;
    localparam logic [2:0] c_STOP      = 3'd4;
    localparam logic [2:0] c_STOP2     = 3'd5;
    localparam logic [2:0] c_WAIT_HIGH = 3'd6;

    logic                   sync_q, rxs_q;
    logic [2:0]             state_q, state_d;
    logic [c_CW-1:0]        cnt_q, cnt_d;
    logic [c_BW-1:0]        bit_q, bit_d;
    logic [DATA_LENGTH-1:0] shift_q, shift_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;
    logic [DATA_LENGTH-1:0] data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   parity_error_q, parity_error_d;
    logic                   frame_error_q, frame_error_d;
    logic                   stop_done;

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q         <= 1'b1;
            rxs_q          <= 1'b1;
            state_q        <= c_IDLE;
            cnt_q          <= '0;
            bit_q          <= '0;
            shift_q        <= '0;
            perr_q         <= 1'b0;
            ferr_q         <= 1'b0;
            data_q         <= '0;
            valid_q        <= 1'b0;
            parity_error_q <= 1'b0;
            frame_error_q  <= 1'b0;
        end else begin
            sync_q         <= serial;
            rxs_q          <= sync_q;
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            bit_q          <= bit_d;
            shift_q        <= shift_d;
            perr_q         <= perr_d;
            ferr_q         <= ferr_d;
            data_q         <= data_d;
            valid_q        <= valid_d;
            parity_error_q <= parity_error_d;
            frame_error_q  <= frame_error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + c_CW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        case (state_q)
            c_IDLE: begin
                cnt_d = '0;
                if (!rxs_q) state_d = c_START;
            end
            c_START: begin
                if (cnt_q == c_CNT_HALF) begin
                    cnt_d = '0;
                    if (rxs_q) begin
                        state_d = c_IDLE;
                    end else begin
                        state_d = c_DATA;
                        bit_d   = '0;
                        perr_d  = 1'b0;
                        ferr_d  = 1'b0;
                    end
                end
            end
            c_DATA: begin
                if (cnt_q == c_CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rxs_q, shift_q[DATA_LENGTH-1:1]};
                    bit_d   = bit_q + c_BW'(1);
                    if (bit_q == c_BIT_LAST) state_d = PARITY ? c_PARITY : c_STOP;
                end
            end
            c_PARITY: begin
                if (cnt_q == c_CNT_LAST) begin
                    cnt_d   = '0;
                    perr_d  = ~(^{shift_q, rxs_q});
                    state_d = c_STOP;
                end
            end
            c_STOP: begin
                if (cnt_q == c_CNT_LAST) begin
                    cnt_d  = '0;
                    ferr_d = ~rxs_q;
                    if (DOUBLE_STOPBIT) state_d = c_STOP2;
                    else                state_d = rxs_q ? c_IDLE : c_WAIT_HIGH;
                end
            end
            c_STOP2: begin
                if (cnt_q == c_CNT_LAST) begin
                    cnt_d   = '0;
                    ferr_d  = ferr_q | ~rxs_q;
                    state_d = (ferr_q | ~rxs_q) ? c_WAIT_HIGH : c_IDLE;
                end
            end
            c_WAIT_HIGH: begin
                cnt_d = '0;
                if (rxs_q) state_d = c_IDLE;
            end
            default: begin
                state_d = c_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs load on the final stop sample; ferr_d already holds the merged stop result.
    always_comb begin
        stop_done = (cnt_q == c_CNT_LAST) &&
                    (((state_q == c_STOP) && !DOUBLE_STOPBIT) || (state_q == c_STOP2));
        valid_d        = stop_done;
        data_d         = data_q;
        parity_error_d = parity_error_q;
        frame_error_d  = frame_error_q;
        if (stop_done) begin
            data_d         = shift_q;
            parity_error_d = perr_q;
            frame_error_d  = ferr_d;
        end
    end

    assign data         = data_q;
    assign valid        = valid_q;
    assign parity_error = parity_error_q;
    assign frame_error  = frame_error_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module      : tb_uart_rx
// Description : Directed self-checking bench for uart_rx (RATIO=4), single and
//               double stop-bit configurations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx;

    localparam int c_R = 4;

    logic       sysclk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ser0 = 1'b1;
    logic       ser1 = 1'b1;
    logic [7:0] d0, d1;
    logic       v0, v1, pe0, pe1, fe0, fe1;

    logic [9:0] q0[$];
    logic [9:0] q1[$];

    int n_vec = 0;
    int n_err = 0;

    always #5 sysclk = ~sysclk;

    uart_rx #(
        .SYSCLK_FREQUENCY_HZ(400), .BAUDRATE(100), .DATA_LENGTH(8),
        .DOUBLE_STOPBIT(1'b0), .PARITY(1'b1)
    ) u_dut0 (
        .sysclk(sysclk), .reset_n(reset_n), .serial(ser0), .data(d0),
        .valid(v0), .parity_error(pe0), .frame_error(fe0)
    );

    uart_rx #(
        .SYSCLK_FREQUENCY_HZ(400), .BAUDRATE(100), .DATA_LENGTH(8),
        .DOUBLE_STOPBIT(1'b1), .PARITY(1'b1)
    ) u_dut1 (
        .sysclk(sysclk), .reset_n(reset_n), .serial(ser1), .data(d1),
        .valid(v1), .parity_error(pe1), .frame_error(fe1)
    );

    always @(negedge sysclk) begin
        if (v0 === 1'b1) q0.push_back({fe0, pe0, d0});
        if (v1 === 1'b1) q1.push_back({fe1, pe1, d1});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int which, input logic b, input int cycles);
        if (which == 0) ser0 = b;
        else            ser1 = b;
        repeat (cycles) @(negedge sysclk);
    endtask

    task automatic tx_frame(input int which, input logic [7:0] d, input logic par,
                            input logic s1, input logic s2, input bit two);
        drive(which, 1'b0, c_R);
        for (int i = 0; i < 8; i++) drive(which, d[i], c_R);
        drive(which, par, c_R);
        drive(which, s1, c_R);
        if (two) drive(which, s2, c_R);
    endtask

    task automatic expect_count(input string tag, input int which, input int n);
        check(tag, (which == 0) ? q0.size() : q1.size(), n);
    endtask

    task automatic pop_check(input string tag, input int which, input logic [7:0] d,
                             input logic pe, input logic fe);
        logic [9:0] e;
        e = 'x;
        if (which == 0) begin
            if (q0.size() > 0) e = q0.pop_front();
        end else begin
            if (q1.size() > 0) e = q1.pop_front();
        end
        check({tag, ".data"}, e[7:0], d);
        check({tag, ".perr"}, e[8], pe);
        check({tag, ".ferr"}, e[9], fe);
    endtask

    initial begin
        #1;
        check("rst.data0", d0, 8'h00);
        check("rst.valid0", v0, 1'b0);
        check("rst.perr0", pe0, 1'b0);
        check("rst.ferr0", fe0, 1'b0);
        check("rst.valid1", v1, 1'b0);
        repeat (3) @(negedge sysclk);
        reset_n = 1'b1;
        repeat (8) @(negedge sysclk);

        // Clean frame, correct odd parity
        tx_frame(0, 8'hA7, 1'b0, 1'b1, 1'b1, 1'b0);
        drive(0, 1'b1, 3 * c_R);
        expect_count("a7.count", 0, 1);
        pop_check("a7", 0, 8'hA7, 1'b0, 1'b0);

        // Wrong parity then right parity
        tx_frame(0, 8'h27, 1'b0, 1'b1, 1'b1, 1'b0);
        drive(0, 1'b1, 3 * c_R);
        expect_count("27bad.count", 0, 1);
        pop_check("27bad", 0, 8'h27, 1'b1, 1'b0);
        tx_frame(0, 8'h27, 1'b1, 1'b1, 1'b1, 1'b0);
        drive(0, 1'b1, 3 * c_R);
        expect_count("27ok.count", 0, 1);
        pop_check("27ok", 0, 8'h27, 1'b0, 1'b0);

        // Stop bit low followed by a long break
        tx_frame(0, 8'h55, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(0, 1'b0, 20 * c_R);
        expect_count("brk.count", 0, 1);
        pop_check("brk", 0, 8'h55, 1'b0, 1'b1);
        check("brk.hold_ferr", fe0, 1'b1);
        drive(0, 1'b1, 4 * c_R);
        expect_count("brk.nomore", 0, 0);
        tx_frame(0, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b0);
        drive(0, 1'b1, 3 * c_R);
        expect_count("3c.count", 0, 1);
        pop_check("3c", 0, 8'h3C, 1'b0, 1'b0);

        // One-cycle glitch on idle line
        drive(0, 1'b0, 1);
        drive(0, 1'b1, 4);
        expect_count("glitch.count", 0, 0);
        tx_frame(0, 8'hF0, 1'b1, 1'b1, 1'b1, 1'b0);
        drive(0, 1'b1, 3 * c_R);
        expect_count("f0.count", 0, 1);
        pop_check("f0", 0, 8'hF0, 1'b0, 1'b0);

        // Reset asserted mid data bit 4
        drive(0, 1'b0, c_R);
        for (int i = 0; i < 4; i++) drive(0, i[0] ? 1'b0 : 1'b1, c_R);
        drive(0, 1'b1, 2);
        #2 reset_n = 1'b0;
        #1;
        check("arst.data0", d0, 8'h00);
        check("arst.valid0", v0, 1'b0);
        @(negedge sysclk);
        reset_n = 1'b1;
        drive(0, 1'b1, 12 * c_R);
        expect_count("arst.novalid", 0, 0);
        tx_frame(0, 8'h81, 1'b1, 1'b1, 1'b1, 1'b0);
        drive(0, 1'b1, 3 * c_R);
        expect_count("81.count", 0, 1);
        pop_check("81", 0, 8'h81, 1'b0, 1'b0);

        // Double stop bits: back-to-back frames, then bad second stop bit
        tx_frame(1, 8'h01, 1'b0, 1'b1, 1'b1, 1'b1);
        tx_frame(1, 8'hFE, 1'b0, 1'b1, 1'b1, 1'b1);
        drive(1, 1'b1, 3 * c_R);
        expect_count("ds.count", 1, 2);
        pop_check("ds01", 1, 8'h01, 1'b0, 1'b0);
        pop_check("dsfe", 1, 8'hFE, 1'b0, 1'b0);
        tx_frame(1, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b1);
        drive(1, 1'b1, 3 * c_R);
        expect_count("ds2.count", 1, 1);
        pop_check("ds2", 1, 8'h5A, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
